// File: rtl/mem_bubble_sorter.sv
// -----------------------------------------------------------------------------
// mem_bubble_sorter
//   In-place bubble-sort engine sitting beside a single-port synchronous word
//   memory. On an accepted start it sorts len words from base_addr upwards
//   (address arithmetic wraps modulo 2**ADDR_W). It reports busy, a one-cycle
//   done pulse and a saturating swap counter.
//
//   Optional build macro: SORT_EARLY_EXIT_EN
//     defined   -> a pass with no swaps ends the sort immediately
//     undefined -> all len-1 passes always run
//
// Ports
//   clk          single clock, all state changes on posedge
//   rst          synchronous active-high reset
//   start        one-cycle request, only honoured in IDLE
//   base_addr    first element address, latched on accepted start
//   len          element count, latched on accepted start
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
//   mem_rd_en    read strobe, mem_rd_data valid the following cycle
//   mem_wr_en    write strobe
//   mem_addr     shared read/write address
//   mem_wr_data  write data
//   mem_rd_data  read data (1-cycle latency)
//   swap_count   swaps in the last/current sort, saturating
// -----------------------------------------------------------------------------
module mem_bubble_sorter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 8,
    parameter int SIGNED_CMP = 1,
    parameter int DESCENDING = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [15:0]       swap_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_CMP  = 3'd3,
        ST_WR_A = 3'd4,
        ST_WR_B = 3'd5,
        ST_NEXT = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    i_r;
    logic [LEN_W-1:0]    j_r;
    logic [DATA_W-1:0]   a_r;
    logic                pass_swap_r;

    logic [ADDR_W-1:0]   addr_j_s;
    logic [ADDR_W-1:0]   addr_j1_s;
    logic [LEN_W-1:0]    last_j_s;
    logic                more_s;
    logic                pass_last_s;
    logic                finish_s;
    logic                swap_s;

    // Ordering primitive; the compare flavour is fixed at elaboration.
    function automatic logic is_less(input logic [DATA_W-1:0] x,
                                     input logic [DATA_W-1:0] y);
        if (SIGNED_CMP != 0) begin
            return ($signed(x) < $signed(y));
        end else begin
            return (x < y);
        end
    endfunction

    // Element addresses for the current pair, wrapping at the top of memory.
    assign addr_j_s  = base_r + ADDR_W'(j_r);
    assign addr_j1_s = addr_j_s + ADDR_W'(1);

    // Inner-loop bound: pair index j runs 0 .. len-2-i within pass i.
    assign last_j_s  = len_r - LEN_W'(2) - i_r;
    assign more_s    = (j_r < last_j_s);

    // Pass i is the last one when i+1 >= len-1; widened so len near max cannot overflow.
    assign pass_last_s = (({1'b0, i_r} + (LEN_W+1)'(2)) >= {1'b0, len_r});

`ifdef SORT_EARLY_EXIT_EN
    assign finish_s = pass_last_s || !pass_swap_r;
`else
    assign finish_s = pass_last_s;
`endif

    // Swap decision: b (arriving on mem_rd_data in CMP) against the registered a.
    assign swap_s = (DESCENDING != 0) ? is_less(a_r, mem_rd_data)
                                      : is_less(mem_rd_data, a_r);

    // Main sequencer. Memory strobes are registered on entry to the state that
    // owns them, so they are visible for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            len_r       <= '0;
            i_r         <= '0;
            j_r         <= '0;
            a_r         <= '0;
            pass_swap_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            swap_count  <= 16'h0000;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        swap_count <= 16'h0000;
                        if (len >= LEN_W'(2)) begin
                            base_r      <= base_addr;
                            len_r       <= len;
                            i_r         <= '0;
                            j_r         <= '0;
                            pass_swap_r <= 1'b0;
                            busy        <= 1'b1;
                            mem_rd_en   <= 1'b1;
                            mem_addr    <= base_addr;
                            state_r     <= ST_RD_A;
                        end else begin
                            // Nothing to sort: complete without touching memory.
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_A: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= addr_j1_s;
                    state_r   <= ST_RD_B;
                end
                ST_RD_B: begin
                    a_r     <= mem_rd_data;
                    state_r <= ST_CMP;
                end
                ST_CMP: begin
                    if (swap_s) begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= addr_j_s;
                        mem_wr_data <= mem_rd_data;
                        state_r     <= ST_WR_A;
                    end else begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_WR_A: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= addr_j1_s;
                    mem_wr_data <= a_r;
                    pass_swap_r <= 1'b1;
                    if (swap_count != 16'hFFFF) begin
                        swap_count <= swap_count + 16'd1;
                    end else begin
                        swap_count <= swap_count;
                    end
                    state_r <= ST_WR_B;
                end
                ST_WR_B: begin
                    state_r <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (more_s) begin
                        j_r       <= j_r + LEN_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr_j1_s;
                        state_r   <= ST_RD_A;
                    end else begin
                        i_r         <= i_r + LEN_W'(1);
                        j_r         <= '0;
                        pass_swap_r <= 1'b0;
                        if (finish_s) begin
                            state_r <= ST_DONE;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_r;
                            state_r   <= ST_RD_A;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bubble_sorter.sv
// -----------------------------------------------------------------------------
// tb_mem_bubble_sorter
//   Directed bench for mem_bubble_sorter. Three instances share clk/rst:
//   0 = signed ascending (default), 1 = unsigned ascending, 2 = descending.
//   Each has its own 1024-word synchronous memory model.
// -----------------------------------------------------------------------------
module tb_mem_bubble_sorter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        start = 3'b000;
    logic [2:0][9:0]   base_addr = '0;
    logic [2:0][7:0]   len = '0;
    logic [2:0]        busy;
    logic [2:0]        done;
    logic [2:0]        rd_en;
    logic [2:0]        wr_en;
    logic [2:0][9:0]   addr;
    logic [2:0][31:0]  wr_data;
    logic [2:0][31:0]  rd_data;
    logic [2:0][15:0]  swap_count;

    logic [31:0] mem [3][1024];
    logic        tb_we = 1'b0;
    int          tb_k = 0;
    logic [9:0]  tb_addr = 10'd0;
    logic [31:0] tb_data = 32'd0;

    int checks = 0;
    int errors = 0;
    int overlaps = 0;
    int strobes [3] = '{0, 0, 0};
    int busy_cyc [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    mem_bubble_sorter u_dut (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]), .len(len[0]),
        .busy(busy[0]), .done(done[0]), .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]),
        .mem_addr(addr[0]), .mem_wr_data(wr_data[0]), .mem_rd_data(rd_data[0]),
        .swap_count(swap_count[0])
    );

    mem_bubble_sorter #(.SIGNED_CMP(0)) u_uns (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]), .len(len[1]),
        .busy(busy[1]), .done(done[1]), .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]),
        .mem_addr(addr[1]), .mem_wr_data(wr_data[1]), .mem_rd_data(rd_data[1]),
        .swap_count(swap_count[1])
    );

    mem_bubble_sorter #(.DESCENDING(1)) u_desc (
        .clk(clk), .rst(rst), .start(start[2]), .base_addr(base_addr[2]), .len(len[2]),
        .busy(busy[2]), .done(done[2]), .mem_rd_en(rd_en[2]), .mem_wr_en(wr_en[2]),
        .mem_addr(addr[2]), .mem_wr_data(wr_data[2]), .mem_rd_data(rd_data[2]),
        .swap_count(swap_count[2])
    );

    // Synchronous single-port memories plus a bench-side preload port.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_en[k]) mem[k][addr[k]] <= wr_data[k];
            if (rd_en[k]) rd_data[k] <= mem[k][addr[k]];
        end
        if (tb_we) mem[tb_k][tb_addr] <= tb_data;
    end

    // Activity monitors sampled away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k] && wr_en[k]) overlaps = overlaps + 1;
            if (rd_en[k] || wr_en[k]) strobes[k] = strobes[k] + 1;
            if (busy[k]) busy_cyc[k] = busy_cyc[k] + 1;
            if (done[k]) done_cnt[k] = done_cnt[k] + 1;
        end
    end

    task automatic load(input int k, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_k = k; tb_addr = a; tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Pulse start; returns 1 ns after the accepting edge.
    task automatic kick(input int k, input logic [9:0] b, input logic [7:0] l);
        @(negedge clk);
        base_addr[k] = b; len[k] = l; start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    // Counts edges until done is seen; -1 on timeout.
    task automatic wait_done(input int k, output int n);
        n = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (done[k]) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy[k], done[k], rd_en[k], wr_en[k], addr[k], wr_data[k], swap_count[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b rd=%b wr=%b addr=%0d wd=%h sc=%0d, expected all 0",
                         k, busy[k], done[k], rd_en[k], wr_en[k], addr[k], wr_data[k], swap_count[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_sort();
        logic [31:0] exp [4];
        int n;
        exp = '{32'd10, 32'd20, 32'd25, 32'd50};
        load(0, 10'd100, 32'd10); load(0, 10'd101, 32'd25);
        load(0, 10'd102, 32'd50); load(0, 10'd103, 32'd20);
        kick(0, 10'd100, 8'd4);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", busy[0]);
        end
        wait_done(0, n);
        checks++;
        if (n != 29) begin
            errors++; $display("FAIL basic_latency: got %0d expected 29", n);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy[0]);
        end
        checks++;
        if (swap_count[0] !== 16'd2) begin
            errors++; $display("FAIL basic_swaps: got %0d expected 2", swap_count[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[0][100+i] !== exp[i]) begin
                errors++; $display("FAIL basic_mem[%0d]: got %0d expected %0d", 100+i, mem[0][100+i], exp[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done[0] !== 1'b0) begin
            errors++; $display("FAIL basic_done_width: got %b expected 0", done[0]);
        end
    endtask

    task automatic test_presorted();
        int n;
        int exp_n;
`ifdef SORT_EARLY_EXIT_EN
        exp_n = 13;
`else
        exp_n = 25;
`endif
        for (int i = 0; i < 4; i++) load(0, 10'(100 + i), 32'(i + 1));
        kick(0, 10'd100, 8'd4);
        wait_done(0, n);
        checks++;
        if (n != exp_n) begin
            errors++; $display("FAIL presorted_latency: got %0d expected %0d", n, exp_n);
        end
        checks++;
        if (swap_count[0] !== 16'd0) begin
            errors++; $display("FAIL presorted_swaps: got %0d expected 0", swap_count[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[0][100+i] !== 32'(i + 1)) begin
                errors++; $display("FAIL presorted_mem[%0d]: got %0d expected %0d", 100+i, mem[0][100+i], i + 1);
            end
        end
    endtask

    task automatic test_signedness();
        logic [31:0] exp_s [3];
        logic [31:0] exp_u [3];
        int n0;
        int n1;
        exp_s = '{32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'h0000_0003};
        exp_u = '{32'h0000_0003, 32'hFFFF_FFF9, 32'hFFFF_FFFB};
        for (int k = 0; k < 2; k++) begin
            load(k, 10'd200, 32'hFFFF_FFFB);
            load(k, 10'd201, 32'h0000_0003);
            load(k, 10'd202, 32'hFFFF_FFF9);
        end
        kick(0, 10'd200, 8'd3);
        wait_done(0, n0);
        kick(1, 10'd200, 8'd3);
        wait_done(1, n1);
        checks++;
        if (n0 != 17 || n1 != 17) begin
            errors++; $display("FAIL sign_latency: got %0d/%0d expected 17/17", n0, n1);
        end
        checks++;
        if (swap_count[0] !== 16'd2 || swap_count[1] !== 16'd2) begin
            errors++; $display("FAIL sign_swaps: got %0d/%0d expected 2/2", swap_count[0], swap_count[1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[0][200+i] !== exp_s[i]) begin
                errors++; $display("FAIL signed_mem[%0d]: got %h expected %h", 200+i, mem[0][200+i], exp_s[i]);
            end
            checks++;
            if (mem[1][200+i] !== exp_u[i]) begin
                errors++; $display("FAIL unsigned_mem[%0d]: got %h expected %h", 200+i, mem[1][200+i], exp_u[i]);
            end
        end
    endtask

    task automatic test_descending();
        logic [31:0] exp [4];
        int n;
        int exp_dup;
`ifdef SORT_EARLY_EXIT_EN
        exp_dup = 9;
`else
        exp_dup = 13;
`endif
        exp = '{32'd50, 32'd25, 32'd20, 32'd10};
        load(2, 10'd100, 32'd10); load(2, 10'd101, 32'd25);
        load(2, 10'd102, 32'd50); load(2, 10'd103, 32'd20);
        kick(2, 10'd100, 8'd4);
        wait_done(2, n);
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL desc_latency: got %0d expected 33", n);
        end
        checks++;
        if (swap_count[2] !== 16'd4) begin
            errors++; $display("FAIL desc_swaps: got %0d expected 4", swap_count[2]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[2][100+i] !== exp[i]) begin
                errors++; $display("FAIL desc_mem[%0d]: got %0d expected %0d", 100+i, mem[2][100+i], exp[i]);
            end
        end
        for (int i = 0; i < 3; i++) load(2, 10'(300 + i), 32'd7);
        kick(2, 10'd300, 8'd3);
        wait_done(2, n);
        checks++;
        if (swap_count[2] !== 16'd0 || n != exp_dup) begin
            errors++; $display("FAIL desc_duplicates: got swaps=%0d lat=%0d expected swaps=0 lat=%0d",
                               swap_count[2], n, exp_dup);
        end
    endtask

    task automatic test_short_len();
        int n;
        int s0;
        int b0;
        for (int l = 0; l < 2; l++) begin
            s0 = strobes[0];
            b0 = busy_cyc[0];
            kick(0, 10'd100, 8'(l));
            wait_done(0, n);
            checks++;
            if (n != 1) begin
                errors++; $display("FAIL short_latency[len=%0d]: got %0d expected 1", l, n);
            end
            repeat (2) @(posedge clk);
            checks++;
            if (strobes[0] != s0 || busy_cyc[0] != b0) begin
                errors++; $display("FAIL short_quiet[len=%0d]: got strobes=%0d busy=%0d expected 0/0",
                                   l, strobes[0] - s0, busy_cyc[0] - b0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        logic [9:0]  wa [4];
        int n;
        exp = '{32'd10, 32'd20, 32'd30, 32'd40};
        wa  = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        load(0, 10'd1021, 32'd99); load(0, 10'd2, 32'd77);
        load(0, 10'd1022, 32'd40); load(0, 10'd1023, 32'd30);
        load(0, 10'd0, 32'd20);    load(0, 10'd1, 32'd10);
        kick(0, 10'd1022, 8'd4);
        wait_done(0, n);
        checks++;
        if (n != 37 || swap_count[0] !== 16'd6) begin
            errors++; $display("FAIL wrap_timing: got lat=%0d swaps=%0d expected 37/6", n, swap_count[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[0][wa[i]] !== exp[i]) begin
                errors++; $display("FAIL wrap_mem[%0d]: got %0d expected %0d", wa[i], mem[0][wa[i]], exp[i]);
            end
        end
        checks++;
        if (mem[0][1021] !== 32'd99 || mem[0][2] !== 32'd77) begin
            errors++; $display("FAIL wrap_canary: got %0d/%0d expected 99/77", mem[0][1021], mem[0][2]);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        load(0, 10'd100, 32'd10); load(0, 10'd101, 32'd25);
        load(0, 10'd102, 32'd50); load(0, 10'd103, 32'd20);
        kick(0, 10'd100, 8'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy[0], done[0], rd_en[0], wr_en[0], addr[0], wr_data[0], swap_count[0]} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b rd=%b wr=%b addr=%0d sc=%0d expected all 0",
                     busy[0], done[0], rd_en[0], wr_en[0], addr[0], swap_count[0]);
        end
        d0 = done_cnt[0];
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        checks++;
        if (done_cnt[0] != d0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt[0] - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        int n;
        exp = '{32'd10, 32'd20, 32'd25, 32'd50};
        load(0, 10'd100, 32'd10); load(0, 10'd101, 32'd25);
        load(0, 10'd102, 32'd50); load(0, 10'd103, 32'd20);
        kick(0, 10'd100, 8'd4);
        repeat (3) @(posedge clk);
        kick(0, 10'd0, 8'd2);
        wait_done(0, n);
        // 4 edges already elapsed since the real accept; done lands on edge 29.
        checks++;
        if (n != 25 || swap_count[0] !== 16'd2) begin
            errors++; $display("FAIL b2b_timing: got lat=%0d swaps=%0d expected 25/2", n, swap_count[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[0][100+i] !== exp[i]) begin
                errors++; $display("FAIL b2b_mem[%0d]: got %0d expected %0d", 100+i, mem[0][100+i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sort();
        test_presorted();
        test_signedness();
        test_descending();
        test_short_len();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (overlaps != 0) begin
            errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlaps);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
